// File: rtl/buffer_ram_slot.sv
// Single buffer-RAM slot: read-pipelined storage with address-range checking and write accounting.
// Optional macro BUFFER_SLOT_RAW_BYPASS_EN forwards same-cycle write data to a colliding read.

package buffer_ram_slot_pkg;
  localparam int E         = 16;
  localparam int FSIZE     = 32;
  localparam int DATA_SIZE = E * FSIZE;

  typedef struct packed {
    logic [31:0]          raddr;
    logic [31:0]          waddr;
    logic [DATA_SIZE-1:0] wdata;
    logic                 wren;
  } buffer_ram_te_fsize_inputs_t;
endpackage

module buffer_ram_slot
  import buffer_ram_slot_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  buffer_ram_te_fsize_inputs_t ram_in,
  output logic [DATA_SIZE-1:0]        ram_out,
  input  logic                        err_clr,
  output logic                        addr_err,
  output logic [31:0]                 wr_count
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("buffer_ram_slot: RD_LAT must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("buffer_ram_slot: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [DATA_SIZE-1:0] mem  [DEPTH];
  logic [DATA_SIZE-1:0] pipe [RD_LAT];
  logic [DATA_SIZE-1:0] stage1_d;

  logic             rd_ok;
  logic             wr_ok;
  logic             wr_commit;
  logic             wr_oor;
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;

  assign rd_ok     = ram_in.raddr < 32'(DEPTH);
  assign wr_ok     = ram_in.waddr < 32'(DEPTH);
  assign ridx      = ram_in.raddr[IDX_W-1:0];
  assign widx      = ram_in.waddr[IDX_W-1:0];
  assign wr_commit = ram_in.wren && wr_ok;
  assign wr_oor    = ram_in.wren && !wr_ok;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stage1_d = '0;
    if (rd_ok) begin
      stage1_d = mem[ridx];
    end
`ifdef BUFFER_SLOT_RAW_BYPASS_EN
    if (wr_commit && rd_ok && (ridx == widx)) begin
      stage1_d = ram_in.wdata;
    end
`endif
  end

  // NOTE: the storage array has no reset; clearing thousands of words would block RAM inference.
  // A write sampled while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (wr_commit && !rst) begin
      mem[widx] <= ram_in.wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= stage1_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign ram_out = pipe[RD_LAT-1];

  // Error set dominates a coincident clear; the write counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
      wr_count <= '0;
    end else begin
      if (wr_oor || !rd_ok) begin
        addr_err <= 1'b1;
      end else if (err_clr) begin
        addr_err <= 1'b0;
      end
      if (wr_commit && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_ram_slot.sv
// Scoreboard bench for buffer_ram_slot: the stimulus side predicts responses from an array model,
// and a negedge monitor pops and compares them when they fall due.

module tb_buffer_ram_slot;
  import buffer_ram_slot_pkg::*;

  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;

  typedef logic [DATA_SIZE-1:0] word_t;

  typedef struct {
    int    due;
    bit    chk;
    word_t data;
  } rd_exp_t;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] cnt;
  } st_exp_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        err_clr = 1'b0;
  buffer_ram_te_fsize_inputs_t ram_in = '0;
  word_t                       ram_out;
  logic                        addr_err;
  logic [31:0]                 wr_count;

  buffer_ram_slot #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_in   (ram_in),
    .ram_out  (ram_out),
    .err_clr  (err_clr),
    .addr_err (addr_err),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rd_exp_t     rdq[$];
  st_exp_t     stq[$];
  word_t       mem_m [DEPTH];
  bit          known [DEPTH];
  bit          err_m;
  logic [31:0] cnt_m;
  int          checks;
  int          failures;
  bit          mon_en;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DATA_SIZE / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Drive one request, then predict its read data and the status after the sampling edge.
  task automatic step(input logic [31:0] ra, input logic [31:0] wa, input word_t wd,
                      input logic we, input logic clr);
    rd_exp_t r;
    @(posedge clk);
    #1;
    ram_in.raddr = ra;
    ram_in.waddr = wa;
    ram_in.wdata = wd;
    ram_in.wren  = we;
    err_clr      = clr;
    r.due = cyc + RD_LAT;
    if (ra >= DEPTH) begin
      r.chk  = 1'b1;
      r.data = '0;
    end else begin
      r.chk  = known[ra];
      r.data = mem_m[ra];
`ifdef BUFFER_SLOT_RAW_BYPASS_EN
      if (we && wa < DEPTH && wa == ra) begin
        r.chk  = 1'b1;
        r.data = wd;
      end
`endif
    end
    rdq.push_back(r);
    if (we && wa < DEPTH) begin
      mem_m[wa] = wd;
      known[wa] = 1'b1;
      if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
    end
    if ((we && wa >= DEPTH) || ra >= DEPTH) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    stq.push_back('{cyc + 1, err_m, cnt_m});
  endtask

  initial begin : monitor
    rd_exp_t r;
    st_exp_t s;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (rdq.size() > 0 && rdq[0].due <= cyc) begin
          r = rdq.pop_front();
          if (r.due < cyc) begin
            checks++;
            failures++;
            $display("FAIL ram_out_missed: due %0d seen at %0d", r.due, cyc);
          end else if (r.chk) begin
            check("ram_out", ram_out, r.data);
          end
        end
        while (stq.size() > 0 && stq[0].due <= cyc) begin
          s = stq.pop_front();
          check("addr_err", word_t'(addr_err), word_t'(s.err));
          check("wr_count", word_t'(wr_count), word_t'(s.cnt));
        end
      end
    end
  end

  task automatic drain();
    int k;
    repeat (RD_LAT + 2) step(0, 0, '0, 1'b0, 1'b0);
    k = 0;
    while ((rdq.size() > 0 || stq.size() > 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rdq.size() > 0 || stq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d read / %0d status expectations left", rdq.size(), stq.size());
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: bench did not finish, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    word_t x;
    word_t y;
    word_t w7;
    logic [31:0] ra;
    logic [31:0] wa;
    err_m = 1'b0;
    cnt_m = '0;
    mon_en = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("reset_ram_out", ram_out, '0);
    check("reset_addr_err", word_t'(addr_err), '0);
    check("reset_wr_count", word_t'(wr_count), '0);
    rst = 1'b0;
    mon_en = 1'b1;

    repeat (4) step(0, 0, '0, 1'b0, 1'b0);

    step(0, 7, {64{8'hA5}}, 1'b1, 1'b0);
    step(7, 0, '0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step(0, i, rand_word(), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(i, 0, '0, 1'b0, 1'b0);

    x = rand_word();
    y = rand_word();
    step(0, 5, x, 1'b1, 1'b0);
    step(5, 5, y, 1'b1, 1'b0);
    step(5, 0, '0, 1'b0, 1'b0);

    step(DEPTH + 3, DEPTH, rand_word(), 1'b1, 1'b0);
    step(0, 0, '0, 1'b0, 1'b0);
    step(1, 0, '0, 1'b0, 1'b1);
    step(1, DEPTH + 100, rand_word(), 1'b1, 1'b1);
    step(2, 0, '0, 1'b0, 1'b1);

    repeat (400) begin
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      wa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      step(ra, wa, rand_word(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    drain();

    w7 = rand_word();
    step(0, 7, w7, 1'b1, 1'b0);
    step(7, 0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_ram_out", ram_out, '0);
    check("rst_mid_addr_err", word_t'(addr_err), '0);
    check("rst_mid_wr_count", word_t'(wr_count), '0);
    rdq.delete();
    stq.delete();
    err_m = 1'b0;
    cnt_m = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_release_ram_out", ram_out, '0);
    mon_en = 1'b1;
    step(7, 0, '0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_ram_slot.md
Name: buffer_ram_slot

Overview:
- Single buffer-RAM slot: the storage responder at the slot end of the module<->slot buffer interconnect.
- Consumes one BufferRAMTEFsizeInputs request per cycle (raddr, waddr, wdata, wren) from the interconnect's slot-side output.
- Returns E*FSIZE-bit read data to the interconnect's slot-side input with fixed pipelined latency.
- SLOT_NUM instances sit behind the interconnect. Each adds address-range checking and write accounting.

Parameters:
- DATA_SIZE, E*FSIZE (512), width of one slot word (E lanes of FSIZE bits).
- DEPTH, 4096, words per slot; power of two, >= 2.
- RD_LAT, 2, cycles from raddr sampled to ram_out valid; legal range 1..4.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ram_in  input  BufferRAMTEFsizeInputs  request: raddr[31:0], waddr[31:0], wdata[E*FSIZE-1:0], wren.
- ram_out  output  DATA_SIZE  read data for the raddr sampled RD_LAT cycles earlier.
- err_clr  input  1  synchronous clear of addr_err.
- addr_err  output  1  sticky: an out-of-range write or read occurred.
- wr_count  output  32  number of committed writes, saturating at 32'hFFFF_FFFF.

Behaviour:
- Reset (async assert, sync-safe release):
  - ram_out = 0; all read-pipeline stages = 0.
  - addr_err = 0; wr_count = 0.
  - Memory contents are not reset.
- Index = addr[$clog2(DEPTH)-1:0]. An address is in range iff addr < DEPTH.
- Write path:
  - On each rising edge with wren=1 and waddr in range, mem[index] <= wdata.
  - The write is visible to reads sampled on the following cycle or later.
  - wr_count increments by 1, saturating.
- Write out of range (wren=1, waddr >= DEPTH):
  - No memory update; wr_count unchanged.
  - addr_err <= 1.
- Read path:
  - Reads occur every cycle; there is no read enable.
  - Stage 1 registers mem[raddr index], or 0 if raddr is out of range.
  - Stages 2..RD_LAT are plain registers.
  - ram_out = last stage. Total latency is exactly RD_LAT cycles.
- Read out of range (raddr >= DEPTH):
  - Pipeline carries 0.
  - addr_err <= 1 on the sampling edge.
- Read/write same index, same cycle: read-first, i.e. old data is returned (see the optional feature).
- addr_err:
  - Set dominates clear. If err_clr=1 and a new error occurs on the same edge, addr_err stays 1.
  - err_clr does not affect wr_count.
- Reset mid-operation:
  - In-flight read data is discarded; outputs go to 0 asynchronously.
  - A write whose edge coincides with rst assertion is not committed.
- Timing: no combinational path from ram_in to ram_out. Stage 1 maps to BRAM/URAM output register.
- Assertion: RD_LAT outside 1..4 is an elaboration error ($error).

Optional Feature:
- Macro: BUFFER_SLOT_RAW_BYPASS_EN.
- Defined: a same-cycle collision forwards wdata into stage 1, so ram_out returns the new data after RD_LAT. A collision is wren=1, both addresses in range, and raddr index == waddr index. Costs a DATA_SIZE-wide comparator+mux before stage 1.
- Undefined: read-first behaviour as above; no forwarding logic is generated.

Test Plan:
- Reset, then idle with raddr=0 and wren=0 -> ram_out=0, addr_err=0, wr_count=0 for all cycles.
- Write 0xA5..A5 to addr 7 at cycle t; read addr 7 at t+1 -> ram_out=0xA5..A5 at t+1+RD_LAT; wr_count=1.
- Back-to-back writes to addr 0..DEPTH-1, then reads 0..DEPTH-1 -> data matches, one word per cycle, constant latency RD_LAT; wr_count=DEPTH.
- Write addr 5 = X, then in one cycle write addr 5 = Y and read addr 5 -> returns X (bypass off) or Y (BUFFER_SLOT_RAW_BYPASS_EN); the next read returns Y.
- Write to DEPTH (4096) and read DEPTH+3 -> mem unchanged, read data 0, addr_err=1.
  - Pulse err_clr alone -> 0.
  - err_clr coincident with a new OOR write -> stays 1.
- Assert rst while a read is in flight for addr 7 -> ram_out=0 immediately, and stays 0 after release; wr_count=0; mem[7] still holds its prior value on a subsequent read.
